// File: rtl/call_pkg.sv
// Shared encodings for the call-control engine: UI commands, signalling
// packet types and call states.
package call_pkg;

    localparam logic [1:0] CMD_NOP    = 2'd0;
    localparam logic [1:0] CMD_DIAL   = 2'd1;
    localparam logic [1:0] CMD_ANSWER = 2'd2;
    localparam logic [1:0] CMD_HANGUP = 2'd3;

    localparam logic [1:0] CALL_REQ  = 2'd0;
    localparam logic [1:0] CALL_ACK  = 2'd1;
    localparam logic [1:0] CALL_END  = 2'd2;
    localparam logic [1:0] CALL_BUSY = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_OUTGOING  = 2'd1,
        ST_INCOMING  = 2'd2,
        ST_CONNECTED = 2'd3
    } call_state_e;

endpackage

// File: rtl/call_controller_if.sv
// UI command, network signalling and status bundle of the call controller.
interface call_controller_if #(
    parameter int unsigned ADDR_W = 8
);
    logic              cmd_valid;
    logic [1:0]        cmd;
    logic [ADDR_W-1:0] cmd_addr;
    logic              cmd_ready;

    logic              rx_valid;
    logic [1:0]        rx_type;
    logic [ADDR_W-1:0] rx_src;

    logic              tx_valid;
    logic [1:0]        tx_type;
    logic [ADDR_W-1:0] tx_dst;
    logic              tx_ready;

    logic [1:0]        state;
    logic [ADDR_W-1:0] peer_addr;
    logic              ring;
    logic              audio_en;
    logic              err;

    modport master (
        output cmd_valid, cmd, cmd_addr, rx_valid, rx_type, rx_src, tx_ready,
        input  cmd_ready, tx_valid, tx_type, tx_dst, state, peer_addr, ring, audio_en, err
    );

    modport slave (
        input  cmd_valid, cmd, cmd_addr, rx_valid, rx_type, rx_src, tx_ready,
        output cmd_ready, tx_valid, tx_type, tx_dst, state, peer_addr, ring, audio_en, err
    );
endinterface

// File: rtl/call_timer.sv
// Ring/answer timer: clearable, saturating up-counter that flags the last
// cycle of the timeout window.
module call_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 50_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired_c
);
    localparam int unsigned   TW   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] LAST = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0] r_count;

    // Holds at LAST so a timeout blocked by a busy tx fires once tx frees up
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable && (r_count != LAST)) begin
            r_count <= r_count + TW'(1);
        end
    end

    assign o_expired_c = (r_count == LAST);

endmodule

// File: rtl/call_controller.sv
// Call state machine between the front-panel UI and the network layer, with a
// single-entry outgoing signalling register.
module call_controller
    import call_pkg::*;
#(
    parameter int unsigned ADDR_W         = 8,
    parameter int unsigned TIMEOUT_CYCLES = 50_000_000
) (
    input logic               clk,
    input logic               reset,
    call_controller_if.slave  bus
);
    call_state_e       r_state;
    call_state_e       w_state_nxt;
    logic [ADDR_W-1:0] r_peer;
    logic [ADDR_W-1:0] w_peer_nxt;

    logic              r_tx_valid;
    logic [1:0]        r_tx_type;
    logic [ADDR_W-1:0] r_tx_dst;
    logic              w_tx_load;
    logic [1:0]        w_tx_type_nxt;
    logic [ADDR_W-1:0] w_tx_dst_nxt;

    logic              r_ring;
    logic              r_audio_en;
    logic              r_err;
    logic              w_err_nxt;

    logic              w_cmd_fire;
    logic              w_from_peer;
    logic              w_timer_en;
    logic              w_timer_clr;
    logic              w_expired;
    logic              w_timeout;

    // Received packets always win; commands wait for both rx and tx to be idle
    assign bus.cmd_ready = !r_tx_valid && !bus.rx_valid;
    assign w_cmd_fire    = bus.cmd_valid && bus.cmd_ready;
    assign w_from_peer   = (bus.rx_src == r_peer);

    assign w_timer_en  = (r_state == ST_OUTGOING) || (r_state == ST_INCOMING);
    assign w_timer_clr = (w_state_nxt != r_state);
    assign w_timeout   = w_timer_en && w_expired && !r_tx_valid && !bus.rx_valid;

    call_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timer (
        .clk         (clk),
        .reset       (reset),
        .i_clear     (w_timer_clr),
        .i_enable    (w_timer_en),
        .o_expired_c (w_expired)
    );

    // Next-state, peer, tx load and error decode
    always_comb begin
        w_state_nxt   = r_state;
        w_peer_nxt    = r_peer;
        w_tx_load     = 1'b0;
        w_tx_type_nxt = r_tx_type;
        w_tx_dst_nxt  = r_tx_dst;
        w_err_nxt     = 1'b0;

        if (bus.rx_valid) begin
            if (r_state == ST_IDLE) begin
                if (bus.rx_type == CALL_REQ) begin
                    w_peer_nxt  = bus.rx_src;
                    w_state_nxt = ST_INCOMING;
                end
            end else if (w_from_peer) begin
                case (r_state)
                    ST_OUTGOING: begin
                        if (bus.rx_type == CALL_ACK) begin
                            w_state_nxt = ST_CONNECTED;
                        end else if ((bus.rx_type == CALL_END) || (bus.rx_type == CALL_BUSY)) begin
                            w_state_nxt = ST_IDLE;
                        end
                    end
                    ST_INCOMING, ST_CONNECTED: begin
                        if (bus.rx_type == CALL_END) begin
                            w_state_nxt = ST_IDLE;
                        end
                    end
                    default: ;
                endcase
            end else if (bus.rx_type == CALL_REQ) begin
                // Third party calling in: answer BUSY, or drop it if tx is full
                if (r_tx_valid) begin
                    w_err_nxt = 1'b1;
                end else begin
                    w_tx_load     = 1'b1;
                    w_tx_type_nxt = CALL_BUSY;
                    w_tx_dst_nxt  = bus.rx_src;
                end
            end
        end else begin
            if (w_timeout) begin
                w_tx_load     = 1'b1;
                w_tx_type_nxt = CALL_END;
                w_tx_dst_nxt  = r_peer;
                w_state_nxt   = ST_IDLE;
                w_err_nxt     = (r_state == ST_OUTGOING);
            end
            // A command accepted alongside a timeout overrides the timeout action
            if (w_cmd_fire) begin
                case (bus.cmd)
                    CMD_DIAL: begin
                        if (r_state == ST_IDLE) begin
                            w_peer_nxt    = bus.cmd_addr;
                            w_tx_load     = 1'b1;
                            w_tx_type_nxt = CALL_REQ;
                            w_tx_dst_nxt  = bus.cmd_addr;
                            w_state_nxt   = ST_OUTGOING;
                        end else begin
                            w_err_nxt = 1'b1;
                        end
                    end
                    CMD_ANSWER: begin
                        if (r_state == ST_INCOMING) begin
                            w_tx_load     = 1'b1;
                            w_tx_type_nxt = CALL_ACK;
                            w_tx_dst_nxt  = r_peer;
                            w_state_nxt   = ST_CONNECTED;
                        end else begin
                            w_err_nxt = 1'b1;
                        end
                    end
                    CMD_HANGUP: begin
                        if (r_state == ST_IDLE) begin
                            w_err_nxt = 1'b1;
                        end else begin
                            w_tx_load     = 1'b1;
                            w_tx_type_nxt = CALL_END;
                            w_tx_dst_nxt  = r_peer;
                            w_state_nxt   = ST_IDLE;
                        end
                    end
                    CMD_NOP: ;
                    default: ;
                endcase
            end
        end
    end

    // State, tx register and status outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_peer     <= '0;
            r_tx_valid <= 1'b0;
            r_tx_type  <= '0;
            r_tx_dst   <= '0;
            r_ring     <= 1'b0;
            r_audio_en <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_peer  <= w_peer_nxt;
            if (w_tx_load) begin
                r_tx_valid <= 1'b1;
                r_tx_type  <= w_tx_type_nxt;
                r_tx_dst   <= w_tx_dst_nxt;
            end else if (r_tx_valid && bus.tx_ready) begin
                r_tx_valid <= 1'b0;
            end
            r_ring     <= (w_state_nxt == ST_INCOMING);
            r_audio_en <= (w_state_nxt == ST_CONNECTED);
            r_err      <= w_err_nxt;
        end
    end

    assign bus.tx_valid  = r_tx_valid;
    assign bus.tx_type   = r_tx_type;
    assign bus.tx_dst    = r_tx_dst;
    assign bus.state     = r_state;
    assign bus.peer_addr = r_peer;
    assign bus.ring      = r_ring;
    assign bus.audio_en  = r_audio_en;
    assign bus.err       = r_err;

endmodule

// File: tb/tb_call_controller.sv
// Directed bench for call_controller: expected tx packets and err pulses are
// queued by the stimulus and retired by an independent negedge monitor.
module tb_call_controller;
    import call_pkg::*;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;

    typedef struct {
        logic [1:0] t;
        logic [7:0] d;
    } tx_exp_t;

    tx_exp_t exp_tx_q[$];
    int      exp_err_q[$];

    call_controller_if #(.ADDR_W(8)) bus ();

    call_controller #(
        .ADDR_W         (8),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_tx(input logic [1:0] t, input logic [7:0] d);
        tx_exp_t e;
        e.t = t;
        e.d = d;
        exp_tx_q.push_back(e);
    endtask

    // Monitor: retire one expectation per accepted tx packet and per err cycle
    always @(negedge clk) begin
        tx_exp_t e;
        if (reset && bus.tx_valid && bus.tx_ready) begin
            if (exp_tx_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL tx_unexpected: got type %0d dst 0x%0h with none expected at %0t",
                         bus.tx_type, bus.tx_dst, $time);
            end else begin
                e = exp_tx_q.pop_front();
                check("tx_type", 32'(bus.tx_type), 32'(e.t));
                check("tx_dst", 32'(bus.tx_dst), 32'(e.d));
            end
        end
        if (reset && bus.err) begin
            n_checks++;
            if (exp_err_q.size() == 0) begin
                n_errors++;
                $display("FAIL err_unexpected: got err=1 expected 0 at %0t", $time);
            end else begin
                void'(exp_err_q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before %0t", $time);
        $fatal(1, "bench timed out");
    end

    initial begin
        n_checks      = 0;
        n_errors      = 0;
        reset         = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd       = CMD_NOP;
        bus.cmd_addr  = '0;
        bus.rx_valid  = 1'b0;
        bus.rx_type   = CALL_REQ;
        bus.rx_src    = '0;
        bus.tx_ready  = 1'b1;

        // Reset values
        #2;
        check("rst_state", 32'(bus.state), 0);
        check("rst_peer", 32'(bus.peer_addr), 0);
        check("rst_tx_valid", 32'(bus.tx_valid), 0);
        check("rst_tx_type", 32'(bus.tx_type), 0);
        check("rst_tx_dst", 32'(bus.tx_dst), 0);
        check("rst_ring", 32'(bus.ring), 0);
        check("rst_audio", 32'(bus.audio_en), 0);
        check("rst_err", 32'(bus.err), 0);
        check("rst_cmd_ready", 32'(bus.cmd_ready), 1);
        tick();
        reset = 1'b1;
        tick();

        // Outgoing call
        bus.cmd_valid = 1'b1; bus.cmd = CMD_DIAL; bus.cmd_addr = 8'h12;
        push_tx(CALL_REQ, 8'h12);
        tick();
        bus.cmd_valid = 1'b0;
        check("dial_state", 32'(bus.state), 1);
        check("dial_peer", 32'(bus.peer_addr), 32'h12);
        check("dial_cmd_ready", 32'(bus.cmd_ready), 0);
        tick();
        check("dial_tx_cleared", 32'(bus.tx_valid), 0);
        bus.rx_valid = 1'b1; bus.rx_type = CALL_ACK; bus.rx_src = 8'h12;
        tick();
        bus.rx_valid = 1'b0;
        check("ack_state", 32'(bus.state), 3);
        check("ack_audio", 32'(bus.audio_en), 1);
        check("ack_ring", 32'(bus.ring), 0);

        // Busy reply while connected
        bus.rx_valid = 1'b1; bus.rx_type = CALL_REQ; bus.rx_src = 8'h77;
        push_tx(CALL_BUSY, 8'h77);
        tick();
        bus.rx_valid = 1'b0;
        check("busy_state", 32'(bus.state), 3);
        check("busy_peer", 32'(bus.peer_addr), 32'h12);
        check("busy_tx_valid", 32'(bus.tx_valid), 1);
        tick();

        // Busy reply dropped while tx is blocked
        bus.tx_ready = 1'b0;
        bus.rx_valid = 1'b1; bus.rx_type = CALL_REQ; bus.rx_src = 8'h78;
        push_tx(CALL_BUSY, 8'h78);
        tick();
        bus.rx_src = 8'h79;
        exp_err_q.push_back(1);
        tick();
        bus.rx_valid = 1'b0;
        check("drop_err", 32'(bus.err), 1);
        check("drop_state", 32'(bus.state), 3);
        check("drop_tx_dst_stable", 32'(bus.tx_dst), 32'h78);
        tick();
        check("drop_err_pulse", 32'(bus.err), 0);
        bus.tx_ready = 1'b1;
        tick();

        // Local hangup
        bus.cmd_valid = 1'b1; bus.cmd = CMD_HANGUP;
        push_tx(CALL_END, 8'h12);
        tick();
        bus.cmd_valid = 1'b0;
        check("hangup_state", 32'(bus.state), 0);
        check("hangup_audio", 32'(bus.audio_en), 0);
        check("hangup_peer_hold", 32'(bus.peer_addr), 32'h12);
        tick();

        // Incoming call answered
        bus.rx_valid = 1'b1; bus.rx_type = CALL_REQ; bus.rx_src = 8'h34;
        tick();
        bus.rx_valid = 1'b0;
        check("in_state", 32'(bus.state), 2);
        check("in_ring", 32'(bus.ring), 1);
        check("in_peer", 32'(bus.peer_addr), 32'h34);
        bus.cmd_valid = 1'b1; bus.cmd = CMD_ANSWER;
        push_tx(CALL_ACK, 8'h34);
        tick();
        bus.cmd_valid = 1'b0;
        check("answer_state", 32'(bus.state), 3);
        check("answer_ring", 32'(bus.ring), 0);
        check("answer_audio", 32'(bus.audio_en), 1);
        tick();

        // Stall and priority: rx CALL_END beats held HANGUP
        bus.cmd_valid = 1'b1; bus.cmd = CMD_HANGUP;
        bus.rx_valid  = 1'b1; bus.rx_type = CALL_END; bus.rx_src = 8'h34;
        #1;
        check("prio_cmd_ready", 32'(bus.cmd_ready), 0);
        tick();
        bus.rx_valid = 1'b0;
        check("prio_state", 32'(bus.state), 0);
        check("prio_no_err", 32'(bus.err), 0);
        exp_err_q.push_back(1);
        tick();
        bus.cmd_valid = 1'b0;
        check("held_hangup_err", 32'(bus.err), 1);
        check("held_hangup_state", 32'(bus.state), 0);
        tick();
        check("held_hangup_err_pulse", 32'(bus.err), 0);

        // Outgoing timeout after exactly 16 cycles
        bus.cmd_valid = 1'b1; bus.cmd = CMD_DIAL; bus.cmd_addr = 8'h05;
        push_tx(CALL_REQ, 8'h05);
        tick();
        bus.cmd_valid = 1'b0;
        check("to_dial_state", 32'(bus.state), 1);
        for (int i = 0; i < 15; i++) begin
            tick();
            check("to_waiting_state", 32'(bus.state), 1);
        end
        push_tx(CALL_END, 8'h05);
        exp_err_q.push_back(1);
        tick();
        check("to_state", 32'(bus.state), 0);
        check("to_err", 32'(bus.err), 1);
        check("to_tx_valid", 32'(bus.tx_valid), 1);
        tick();
        check("to_err_pulse", 32'(bus.err), 0);

        // Reset mid-call with tx pending
        bus.cmd_valid = 1'b1; bus.cmd = CMD_DIAL; bus.cmd_addr = 8'h12;
        push_tx(CALL_REQ, 8'h12);
        tick();
        bus.cmd_valid = 1'b0;
        tick();
        bus.rx_valid = 1'b1; bus.rx_type = CALL_ACK; bus.rx_src = 8'h12;
        tick();
        bus.tx_ready = 1'b0;
        bus.rx_type  = CALL_REQ; bus.rx_src = 8'h55;
        tick();
        bus.rx_valid = 1'b0;
        check("mid_state", 32'(bus.state), 3);
        check("mid_tx_valid", 32'(bus.tx_valid), 1);
        #2;
        reset = 1'b0;
        #1;
        check("arst_state", 32'(bus.state), 0);
        check("arst_peer", 32'(bus.peer_addr), 0);
        check("arst_tx_valid", 32'(bus.tx_valid), 0);
        check("arst_tx_type", 32'(bus.tx_type), 0);
        check("arst_tx_dst", 32'(bus.tx_dst), 0);
        check("arst_ring", 32'(bus.ring), 0);
        check("arst_audio", 32'(bus.audio_en), 0);
        check("arst_err", 32'(bus.err), 0);
        #3;
        reset = 1'b1;
        bus.tx_ready = 1'b1;
        tick();
        check("post_rst_state", 32'(bus.state), 0);
        check("post_rst_tx_valid", 32'(bus.tx_valid), 0);
        tick();

        check("tx_queue_drained", 32'(exp_tx_q.size()), 0);
        check("err_queue_drained", 32'(exp_err_q.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/call_controller.md
# call_controller

Call-control engine for the telephony design. Consumes the command/address stream produced by the front-panel user interface and runs the call state machine: IDLE, OUTGOING, INCOMING and CONNECTED. It emits and consumes call-signalling packets toward the network layer. It reports call state, ringing and audio-enable back to the UI, display and audio path.

## Interface
- `ADDR_W`, 8, station address width
- `TIMEOUT_CYCLES`, 50_000_000, ring/answer timeout in clk cycles (≥2)

Ports:
- `clk`  in  1  system clock
- `reset`  in  1  asynchronous, active-low reset
- `cmd_valid`  in  1  UI command present
- `cmd`  in  2  0 NOP, 1 DIAL, 2 ANSWER, 3 HANGUP
- `cmd_addr`  in  ADDR_W  destination for DIAL; ignored otherwise
- `cmd_ready`  out  1  command accepted when `cmd_valid & cmd_ready`
- `rx_valid`  in  1  one-cycle pulse; signalling packet received; always consumed
- `rx_type`  in  2  0 CALL_REQ, 1 CALL_ACK, 2 CALL_END, 3 BUSY
- `rx_src`  in  ADDR_W  sender address
- `tx_valid`  out  1  outgoing signalling packet pending
- `tx_type`  out  2  same encoding as `rx_type`
- `tx_dst`  out  ADDR_W  destination address
- `tx_ready`  in  1  network accepts packet when `tx_valid & tx_ready`
- `state`  out  2  0 IDLE, 1 OUTGOING, 2 INCOMING, 3 CONNECTED
- `peer_addr`  out  ADDR_W  current peer
- `ring`  out  1  high while in INCOMING
- `audio_en`  out  1  high while in CONNECTED
- `err`  out  1  one-cycle pulse on illegal command, timeout, or dropped reply

## Operation
- `cmd_ready = !tx_valid & !rx_valid`. Incoming packets take priority; commands stall.
- Single-entry tx register. Loading it sets `tx_valid`. It clears on handshake.
- "Send X" below means load tx with (X, peer).
- IDLE:
  - DIAL A: peer←A; send CALL_REQ; go to OUTGOING.
  - rx CALL_REQ from S: peer←S; go to INCOMING.
  - ANSWER/HANGUP: consumed; `err` pulse.
  - NOP: consumed, no effect.
  - Other rx: ignored.
- OUTGOING:
  - rx CALL_ACK from peer: go to CONNECTED.
  - rx CALL_END or BUSY from peer: go to IDLE.
  - HANGUP: send CALL_END; go to IDLE.
  - Timeout: send CALL_END; go to IDLE; `err` pulse.
- INCOMING:
  - ANSWER: send CALL_ACK; go to CONNECTED.
  - HANGUP: send CALL_END; go to IDLE.
  - rx CALL_END from peer: go to IDLE.
  - Timeout: send CALL_END; go to IDLE (no `err`).
- CONNECTED:
  - HANGUP: send CALL_END; go to IDLE.
  - rx CALL_END from peer: go to IDLE.
- Any non-IDLE state:
  - rx CALL_REQ from a non-peer S: send BUSY to S. If tx is occupied, drop the reply and pulse `err`. State is unchanged.
  - Non-CALL_REQ packets from a non-peer: ignored.
  - DIAL: `err` pulse. ANSWER outside INCOMING: `err` pulse.
- `peer_addr` holds its last value after returning to IDLE.

## Timing
- Reset values: `state`=IDLE, `peer_addr`=0, `tx_valid`=0, `tx_type`=0, `tx_dst`=0, `ring`=0, `audio_en`=0, `err`=0, timer=0.
- All outputs are registered. `cmd_ready` is combinational from registered `tx_valid` and the `rx_valid` input.
- Command or packet at edge N updates `state`, `ring`, `audio_en` and `tx_*` at edge N (visible in cycle N+1).
- `tx_type`/`tx_dst` stay stable while `tx_valid` is high.
- Timer width is `$clog2(TIMEOUT_CYCLES+1)`.
  - Clears on every state change.
  - Counts each cycle in OUTGOING/INCOMING.
  - Timeout fires when the count reaches `TIMEOUT_CYCLES-1` (state left after exactly `TIMEOUT_CYCLES` cycles).
  - If tx is occupied at timeout, the timer saturates and the timeout fires on the first cycle tx is free.
  - rx in the same cycle as a timeout wins; the timeout is discarded.
- Reset asserted mid-call returns to IDLE immediately and drops any pending tx without a handshake.

## Structure
- Shared package `call_pkg`: command codes, packet type codes, state encodings, CALL_* localparams.
- One natural sub-module: `call_timer` (clear, enable, saturating count, `expired` output, parameterised by `TIMEOUT_CYCLES`).
- The FSM and the tx register stay in `call_controller`.

## Test plan
(Bench uses `ADDR_W`=8, `TIMEOUT_CYCLES`=16.)
- **Outgoing call:** DIAL 0x12, hold `tx_ready`=1.
  - Expect one tx CALL_REQ→0x12 and `state`=1.
  - Then rx CALL_ACK from 0x12: `state`=3, `audio_en`=1.
- **Incoming call:** rx CALL_REQ from 0x34.
  - Expect `state`=2, `ring`=1, `peer_addr`=0x34.
  - ANSWER: tx CALL_ACK→0x34, `state`=3, `ring`=0.
- **Timeout:** DIAL 0x05 with no reply.
  - Exactly 16 cycles later: tx CALL_END→0x05, `state`=0, one-cycle `err`.
- **Busy while connected:** connected to 0x12, rx CALL_REQ from 0x77.
  - Expect tx BUSY→0x77; `state` stays 3.
  - Repeat with `tx_ready`=0 and tx already pending: reply dropped, `err` pulse.
- **Stall and priority:** `cmd_valid` HANGUP and `rx_valid` CALL_END from peer in the same cycle.
  - Expect `cmd_ready`=0 and `state`=0 next cycle.
  - The still-held HANGUP is then consumed in IDLE with an `err` pulse.
- **Reset mid-call:** in CONNECTED with `tx_valid`=1, assert `reset` low asynchronously.
  - Expect all outputs at reset values before the next clk edge.
